eth_pcs_rx_descrambler: RTL and testbench

Receive-path stage directly downstream of the RX gearbox in the 10GBASE-R PCS. It consumes the gearbox's header and 32-bit data streams and self-synchronously descrambles the payload with the 1 + x^39 + x^58 polynomial. It then assembles each 2-bit sync header and two data words into one 66-bit block for the 64b/66b decoder. It also flags header/data sequencing faults and suppresses output while block lock is absent.

---
 rtl/eth_pcs_rx_descrambler.sv | 128 ++++++++++++
 tb/tb_eth_pcs_rx_descrambler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_rx_descrambler.sv
// 10GBASE-R RX descrambler (1 + x^39 + x^58) and 66-bit block assembler.
// Pairs each sync header with two descrambled 32-bit words.
module eth_pcs_rx_descrambler #(
  parameter int W_DATA       = 32,
  parameter int W_SYNC       = 2,
  parameter bit DESCR_BYPASS = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_hdr_valid,
  input  logic [W_SYNC-1:0]     i_hdr,
  input  logic                  i_data_valid,
  input  logic [W_DATA-1:0]     i_data,
  input  logic                  i_rx_lock,
  output logic                  o_blk_valid,
  output logic [W_SYNC-1:0]     o_blk_hdr,
  output logic [2*W_DATA-1:0]   o_blk_data,
  output logic                  o_seq_err
);

  localparam int W_ST = 58;

  logic [W_ST-1:0]     scr_q;
  logic [W_ST-1:0]     scr_d;
  logic [W_DATA-1:0]   d39;
  logic [W_DATA-1:0]   d58;
  logic [W_DATA-1:0]   descr;

  logic                wcnt_q;
  logic                wcnt_d;
  logic                pend_q;
  logic                pend_d;
  logic                pend_eff;
  logic                wcnt_eff;
  logic [W_SYNC-1:0]   hdr_q;
  logic [W_SYNC-1:0]   hdr_d;
  logic [W_DATA-1:0]   w0_q;
  logic [W_DATA-1:0]   w0_d;
  logic                blk_v_d;
  logic                seq_err_d;
  logic [W_SYNC-1:0]   blk_hdr_d;
  logic [2*W_DATA-1:0] blk_data_d;

  // Taps never reach into the current word while W_DATA <= 39.
  always_comb begin
    d39 = '0;
    d58 = '0;
    for (int i = 0; i < W_DATA; i++) begin
      d39[i] = scr_q[38-i];
      d58[i] = scr_q[57-i];
    end
    descr = i_data ^ ({W_DATA{!DESCR_BYPASS}} & (d39 ^ d58));
  end

  always_comb begin
    scr_d = '0;
    for (int k = 0; k < W_DATA; k++) begin
      scr_d[k] = i_data[W_DATA-1-k];
    end
    scr_d[W_ST-1:W_DATA] = scr_q[W_ST-1-W_DATA:0];
  end

  always_comb begin
    wcnt_d     = wcnt_q;
    pend_d     = pend_q;
    hdr_d      = hdr_q;
    w0_d       = w0_q;
    blk_v_d    = 1'b0;
    seq_err_d  = 1'b0;
    blk_hdr_d  = o_blk_hdr;
    blk_data_d = o_blk_data;
    pend_eff   = pend_q;
    wcnt_eff   = wcnt_q;
    if (!i_rx_lock) begin
      wcnt_d = 1'b0;
      pend_d = 1'b0;
    end else begin
      if (i_hdr_valid) begin
        hdr_d     = i_hdr;
        pend_d    = 1'b1;
        wcnt_d    = 1'b0;
        seq_err_d = wcnt_q;
        pend_eff  = 1'b1;
        wcnt_eff  = 1'b0;
      end
      // A word in the header cycle opens the new block.
      if (i_data_valid && pend_eff) begin
        if (!wcnt_eff) begin
          w0_d   = descr;
          wcnt_d = 1'b1;
        end else begin
          blk_v_d    = 1'b1;
          blk_hdr_d  = hdr_q;
          blk_data_d = {descr, w0_q};
          pend_d     = 1'b0;
          wcnt_d     = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      scr_q       <= '0;
      wcnt_q      <= 1'b0;
      pend_q      <= 1'b0;
      hdr_q       <= '0;
      w0_q        <= '0;
      o_blk_valid <= 1'b0;
      o_seq_err   <= 1'b0;
      o_blk_hdr   <= '0;
      o_blk_data  <= '0;
    end else begin
      if (i_data_valid) begin
        scr_q <= scr_d;
      end
      wcnt_q      <= wcnt_d;
      pend_q      <= pend_d;
      hdr_q       <= hdr_d;
      w0_q        <= w0_d;
      o_blk_valid <= blk_v_d;
      o_seq_err   <= seq_err_d;
      o_blk_hdr   <= blk_hdr_d;
      o_blk_data  <= blk_data_d;
    end
  end

endmodule

// File: tb/tb_eth_pcs_rx_descrambler.sv
// Bench for eth_pcs_rx_descrambler: bit-serial scrambler and
// descrambler reference with a block-level expectation model.
module tb_eth_pcs_rx_descrambler;

  logic        clk;
  logic        rst_n;
  logic        hdr_valid;
  logic [1:0]  hdr;
  logic        data_valid;
  logic [31:0] data;
  logic        rx_lock;
  logic        blk_valid;
  logic [1:0]  blk_hdr;
  logic [63:0] blk_data;
  logic        seq_err;

  eth_pcs_rx_descrambler dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_hdr_valid  (hdr_valid),
    .i_hdr        (hdr),
    .i_data_valid (data_valid),
    .i_data       (data),
    .i_rx_lock    (rx_lock),
    .o_blk_valid  (blk_valid),
    .o_blk_hdr    (blk_hdr),
    .o_blk_data   (blk_data),
    .o_seq_err    (seq_err)
  );

  typedef struct {
    bit [63:0] data;
    bit        skip;
  } pay_t;

  int total;
  int bad;
  int n_valid;
  int n_err;
  bit lock;

  bit   sh[$];
  bit   dh[$];
  pay_t pq[$];

  logic        e_v;
  logic        e_err;
  logic [1:0]  e_hdr;
  logic [63:0] e_data;
  bit          m_pend;
  bit          m_cnt;
  bit [1:0]    m_hdr;
  bit [31:0]   m_w0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    dh.delete();
    for (int i = 0; i < 58; i++) dh.push_back(1'b0);
    e_v    = 1'b0;
    e_err  = 1'b0;
    e_hdr  = '0;
    e_data = '0;
    m_pend = 1'b0;
    m_cnt  = 1'b0;
    m_hdr  = '0;
    m_w0   = '0;
  endtask

  // dh/sh hold the last 58 line bits, index 0 oldest (58 bits back).
  task automatic descr_word(input bit [31:0] c, output bit [31:0] p);
    for (int i = 0; i < 32; i++) begin
      p[i] = c[i] ^ dh[19] ^ dh[0];
      dh.push_back(c[i]);
      void'(dh.pop_front());
    end
  endtask

  task automatic scr_word(input bit [31:0] p, output bit [31:0] s);
    for (int i = 0; i < 32; i++) begin
      s[i] = p[i] ^ sh[19] ^ sh[0];
      sh.push_back(s[i]);
      void'(sh.pop_front());
    end
  endtask

  task automatic step(input bit hv, input bit [1:0] h,
                      input bit dv, input bit [31:0] d);
    pay_t      pe;
    bit [31:0] dw;
    @(posedge clk);
    #1;
    check("blk_valid", blk_valid, e_v);
    check("seq_err", seq_err, e_err);
    check("blk_hdr", blk_hdr, e_hdr);
    check("blk_data", blk_data, e_data);
    if (blk_valid === 1'b1) n_valid++;
    if (seq_err === 1'b1) n_err++;
    if (e_v && pq.size() > 0) begin
      pe = pq.pop_front();
      if (!pe.skip) check("payload", blk_data, pe.data);
    end
    hdr_valid  = hv;
    hdr        = h;
    data_valid = dv;
    data       = d;
    rx_lock    = lock;
    e_v   = 1'b0;
    e_err = 1'b0;
    dw    = '0;
    if (dv) descr_word(d, dw);
    if (!lock) begin
      m_cnt  = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (hv) begin
        e_err  = m_cnt;
        m_hdr  = h;
        m_pend = 1'b1;
        m_cnt  = 1'b0;
      end
      if (dv && m_pend) begin
        if (!m_cnt) begin
          m_w0  = dw;
          m_cnt = 1'b1;
        end else begin
          e_v    = 1'b1;
          e_hdr  = m_hdr;
          e_data = {dw, m_w0};
          m_pend = 1'b0;
          m_cnt  = 1'b0;
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, $urandom);
  endtask

  // mode 0: hdr, w0, w1; 1: hdr+w0, w1; 2: hdr+w0, gap, w1;
  // 3: stray word, then as mode 0.
  task automatic send_block(input bit [1:0] h, input bit [63:0] p,
                            input int mode, input bit skip);
    bit [31:0] st;
    bit [31:0] s0;
    bit [31:0] s1;
    if (mode == 3) begin
      scr_word($urandom, st);
      step(1'b0, 2'b00, 1'b1, st);
    end
    scr_word(p[31:0], s0);
    scr_word(p[63:32], s1);
    if (lock) pq.push_back('{data: p, skip: skip});
    case (mode)
      1: begin
        step(1'b1, h, 1'b1, s0);
        step(1'b0, 2'b00, 1'b1, s1);
      end
      2: begin
        step(1'b1, h, 1'b1, s0);
        step(1'b0, 2'b00, 1'b0, $urandom);
        step(1'b0, 2'b00, 1'b1, s1);
      end
      default: begin
        step(1'b1, h, 1'b0, $urandom);
        step(1'b0, 2'b00, 1'b1, s0);
        step(1'b0, 2'b00, 1'b1, s1);
      end
    endcase
  endtask

  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valid", blk_valid, 1'b0);
    check("rstmid_err", seq_err, 1'b0);
    check("rstmid_hdr", blk_hdr, 2'b00);
    check("rstmid_data", blk_data, 64'h0);
    model_reset();
    hdr_valid  = 1'b0;
    data_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int        v0;
    int        e0;
    bit [31:0] s;
    total      = 0;
    bad        = 0;
    n_valid    = 0;
    n_err      = 0;
    lock       = 1'b1;
    rst_n      = 1'b0;
    hdr_valid  = 1'b0;
    hdr        = '0;
    data_valid = 1'b0;
    data       = '0;
    rx_lock    = 1'b1;
    for (int i = 0; i < 58; i++) sh.push_back(1'b1);
    model_reset();
    #1;
    check("rst_valid", blk_valid, 1'b0);
    check("rst_err", seq_err, 1'b0);
    check("rst_hdr", blk_hdr, 2'b00);
    check("rst_data", blk_data, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    step(1'b1, 2'b01, 1'b1, 32'h0000_0001);
    step(1'b0, 2'b00, 1'b1, 32'h0000_0000);
    idle();
    check("vec_valid", blk_valid, 1'b1);
    check("vec_hdr", blk_hdr, 2'b01);
    check("vec_data", blk_data, 64'h0400_0080_0000_0001);
    idle();

    for (int i = 0; i < 100; i++) begin
      send_block(2'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 3), i == 0);
    end
    idle();

    v0 = n_valid;
    e0 = n_err;
    step(1'b1, 2'($urandom), 1'b0, $urandom);
    scr_word($urandom, s);
    step(1'b0, 2'b00, 1'b1, s);
    send_block(2'($urandom), {$urandom, $urandom}, 0, 1'b0);
    idle();
    check("seq_err_cnt", n_err - e0, 1);
    check("seq_blk_cnt", n_valid - v0, 1);

    lock = 1'b0;
    v0   = n_valid;
    for (int i = 0; i < 10; i++) begin
      send_block(2'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 3), 1'b0);
    end
    idle();
    check("unlock_cnt", n_valid - v0, 0);
    lock = 1'b1;
    send_block(2'b10, {$urandom, $urandom}, 1, 1'b0);
    idle();
    check("relock_cnt", n_valid - v0, 1);

    scr_word($urandom, s);
    step(1'b1, 2'b01, 1'b1, s);
    reset_mid();
    v0 = n_valid;
    scr_word($urandom, s);
    step(1'b0, 2'b00, 1'b1, s);
    idle();
    idle();
    check("postrst_none", n_valid - v0, 0);
    send_block(2'b10, {$urandom, $urandom}, 0, 1'b1);
    idle();
    check("postrst_cnt", n_valid - v0, 1);

    idle();
    v0 = n_valid;
    e0 = n_err;
    for (int i = 0; i < 500; i++) begin
      send_block(2'($urandom), {$urandom, $urandom}, 1, 1'b0);
    end
    idle();
    check("burst_valid", n_valid - v0, 500);
    check("burst_err", n_err - e0, 0);
    check("pq_empty", pq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
